// File: rtl/qm_fetch_if.sv
// Instruction-memory request/response port of the qm fetch stage.
// master = fetch side (drives request), slave = memory side (drives response).
interface qm_fetch_if;
  logic [31:0] im_addr;
  logic        im_valid;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic        im_rvalid;

  modport master (
    output im_addr,
    output im_valid,
    input  im_ready,
    input  im_rdata,
    input  im_rvalid
  );

  modport slave (
    input  im_addr,
    input  im_valid,
    output im_ready,
    output im_rdata,
    output im_rvalid
  );
endinterface

// File: rtl/qm_fetch.sv
// qm instruction fetch stage: PC, single-outstanding imem fetch, stall hold buffer, redirect.
// Optional QM_FETCH_ALIGN_CHECK_EN: misaligned PC raises do_AdEL and halts until redirect.
module qm_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  qm_fetch_if.master  im,
  input  logic        di_stall,
  input  logic        di_redirect,
  input  logic [31:0] di_target,
  output logic [31:0] do_IR,
  output logic [31:0] do_NPC,
  output logic        do_valid,
  output logic        do_AdEL
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_HALT = 3'd4
  } state_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] hold_ir_r, hold_ir_s;
  logic [31:0] hold_npc_r, hold_npc_s;
  logic        discard_r, discard_s;
  logic [31:0] ir_s, npc_s;
  logic        valid_s, adel_s;
  logic        misalign_s;

`ifdef QM_FETCH_ALIGN_CHECK_EN
  assign misalign_s = (pc_r[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  assign im.im_addr  = {pc_r[31:2], 2'b00};
  assign im.im_valid = (state_r == ST_REQ) && !misalign_s;

  // Next-state, PC, hold buffer and output-register update.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    discard_s  = discard_r;
    hold_ir_s  = hold_ir_r;
    hold_npc_s = hold_npc_r;
    npc_s      = do_NPC;
    if (di_stall) begin
      ir_s    = do_IR;
      valid_s = do_valid;
      adel_s  = do_AdEL;
    end else begin
      ir_s    = 32'h0;
      valid_s = 1'b0;
      adel_s  = 1'b0;
    end

    if (di_redirect) begin
      // Flush wins over stall; any buffered or in-flight word becomes stale.
      pc_s       = di_target;
      ir_s       = 32'h0;
      valid_s    = 1'b0;
      adel_s     = 1'b0;
      hold_ir_s  = 32'h0;
      hold_npc_s = 32'h0;
      case (state_r)
        ST_REQ: begin
          if (!misalign_s && im.im_ready) begin
            discard_s = 1'b1;
            state_s   = ST_WAIT;
          end else begin
            state_s = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (im.im_rvalid) begin
            discard_s = 1'b0;
            state_s   = ST_REQ;
          end else begin
            discard_s = 1'b1;
            state_s   = ST_WAIT;
          end
        end
        default: state_s = ST_REQ;
      endcase
    end else begin
      case (state_r)
        ST_IDLE: state_s = ST_REQ;
        ST_REQ: begin
          if (misalign_s) begin
            if (!di_stall) begin
              ir_s    = 32'h0;
              npc_s   = pc_plus4(pc_r);
              valid_s = 1'b1;
              adel_s  = 1'b1;
              state_s = ST_HALT;
            end else begin
              state_s = ST_REQ;
            end
          end else if (im.im_ready) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (!im.im_rvalid) begin
            state_s = ST_WAIT;
          end else if (discard_r) begin
            discard_s = 1'b0;
            state_s   = ST_REQ;
          end else if (!di_stall) begin
            ir_s    = im.im_rdata;
            npc_s   = pc_plus4(pc_r);
            valid_s = 1'b1;
            adel_s  = 1'b0;
            pc_s    = pc_plus4(pc_r);
            state_s = ST_REQ;
          end else begin
            hold_ir_s  = im.im_rdata;
            hold_npc_s = pc_plus4(pc_r);
            state_s    = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!di_stall) begin
            ir_s    = hold_ir_r;
            npc_s   = hold_npc_r;
            valid_s = 1'b1;
            adel_s  = 1'b0;
            pc_s    = hold_npc_r;
            state_s = ST_REQ;
          end else begin
            state_s = ST_HOLD;
          end
        end
        ST_HALT: state_s = ST_HALT;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State, PC, hold buffer and registered decode outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_VECTOR;
      discard_r  <= 1'b0;
      hold_ir_r  <= 32'h0;
      hold_npc_r <= 32'h0;
      do_IR      <= 32'h0;
      do_NPC     <= 32'h0;
      do_valid   <= 1'b0;
      do_AdEL    <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      discard_r  <= discard_s;
      hold_ir_r  <= hold_ir_s;
      hold_npc_r <= hold_npc_s;
      do_IR      <= ir_s;
      do_NPC     <= npc_s;
      do_valid   <= valid_s;
      do_AdEL    <= adel_s;
    end
  end

endmodule

// File: tb/tb_qm_fetch.sv
// Self-checking bench for qm_fetch: directed scenarios plus a transaction-level
// model of the expected request-address and delivered-instruction streams.
module tb_qm_fetch;
  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        di_stall, di_redirect;
  logic [31:0] di_target;
  logic [31:0] do_IR, do_NPC;
  logic        do_valid, do_AdEL;

  qm_fetch_if imb();

  qm_fetch #(.RESET_VECTOR(RV)) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .im         (imb.master),
    .di_stall   (di_stall),
    .di_redirect(di_redirect),
    .di_target  (di_target),
    .do_IR      (do_IR),
    .do_NPC     (do_NPC),
    .do_valid   (do_valid),
    .do_AdEL    (do_AdEL)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory: word content is the word address XOR a key, response after mem_lat cycles.
  int          mem_lat = 1;
  logic [31:0] mem_xor = 32'h0;
  logic        mem_acc_ev = 1'b0;
  logic [31:0] mem_acc_addr = 32'h0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ mem_xor;
  endfunction

  always @(posedge clk) begin
    #1;
    if (mem_acc_ev) begin
      mem_cnt  = mem_lat;
      mem_addr = mem_acc_addr;
    end
    imb.im_rvalid = 1'b0;
    imb.im_rdata  = 32'hDEAD_BEEF;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imb.im_rvalid = 1'b1;
        imb.im_rdata  = mem_word(mem_addr);
      end
    end
  end

  // Model state: next address that must be requested, next PC that must be delivered.
  bit          started = 1'b0;
  logic        prev_rst, prev_stall, prev_redir;
  logic [31:0] p_ir, p_npc;
  logic        p_v, p_adel;
  logic [31:0] exp_req = RV;
  logic [31:0] exp_out = RV;
  bit          outstanding = 1'b0;
  bit          halted = 1'b0;
  int          deliveries = 0;

  task automatic deliver_word();
    check32("deliver_ir", do_IR, mem_word(exp_out));
    check32("deliver_npc", do_NPC, exp_out + 32'd4);
    check32("deliver_adel", do_AdEL, 1'b0);
    exp_out = exp_out + 32'd4;
  endtask

  always @(negedge clk) begin
    logic acc;
    acc = imb.im_valid && imb.im_ready;
    if (started) begin
      if (prev_rst) begin
        check32("rst_valid", do_valid, 1'b0);
        check32("rst_ir", do_IR, 32'h0);
        check32("rst_npc", do_NPC, 32'h0);
        check32("rst_adel", do_AdEL, 1'b0);
      end else if (prev_redir) begin
        check32("flush_valid", do_valid, 1'b0);
        check32("flush_ir", do_IR, 32'h0);
        check32("flush_npc", do_NPC, p_npc);
        check32("flush_adel", do_AdEL, 1'b0);
      end else if (prev_stall) begin
        check32("stall_ir", do_IR, p_ir);
        check32("stall_npc", do_NPC, p_npc);
        check32("stall_valid", do_valid, p_v);
        check32("stall_adel", do_AdEL, p_adel);
      end else if (do_valid) begin
        deliveries++;
        check32("deliver_not_halted", halted, 1'b0);
`ifdef QM_FETCH_ALIGN_CHECK_EN
        if (exp_out[1:0] != 2'b00) begin
          check32("adel_ir", do_IR, 32'h0);
          check32("adel_npc", do_NPC, exp_out + 32'd4);
          check32("adel_flag", do_AdEL, 1'b1);
          halted = 1'b1;
        end else begin
          deliver_word();
        end
`else
        deliver_word();
`endif
      end else begin
        check32("bubble_ir", do_IR, 32'h0);
        check32("bubble_npc", do_NPC, p_npc);
        check32("bubble_adel", do_AdEL, 1'b0);
      end
    end

    if (rst) begin
      outstanding = 1'b0;
      halted      = 1'b0;
      exp_req     = RV;
      exp_out     = RV;
    end else begin
      if (outstanding) check32("one_outstanding", imb.im_valid, 1'b0);
      if (halted) check32("halt_no_req", imb.im_valid, 1'b0);
      if (imb.im_rvalid) outstanding = 1'b0;
      if (di_redirect) begin
        exp_req = di_target;
        exp_out = di_target;
        halted  = 1'b0;
      end else if (acc) begin
        check32("req_addr", imb.im_addr, {exp_req[31:2], 2'b00});
`ifdef QM_FETCH_ALIGN_CHECK_EN
        check32("req_aligned", {30'h0, exp_req[1:0]}, 32'h0);
`endif
        exp_req = exp_req + 32'd4;
      end
      if (acc) outstanding = 1'b1;
    end

    mem_acc_ev   = acc;
    mem_acc_addr = imb.im_addr;
    prev_rst     = rst;
    prev_stall   = di_stall;
    prev_redir   = di_redirect;
    p_ir         = do_IR;
    p_npc        = do_NPC;
    p_v          = do_valid;
    p_adel       = do_AdEL;
    started      = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ivalid(input string nm);
    int n;
    n = 0;
    while (imb.im_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check32(nm, imb.im_valid, 1'b1);
  endtask

  task automatic redirect_to(input logic [31:0] t);
    di_redirect = 1'b1;
    di_target   = t;
    tick();
    di_redirect = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          cnt;
    bit          seen;
    logic [31:0] t;
    rst = 1'b1;
    di_stall = 1'b0;
    di_redirect = 1'b0;
    di_target = 32'h0;
    imb.im_ready = 1'b1;
    repeat (3) tick();

    // 1: reset release, sequential fetch every 2 cycles, rdata = address
    rst = 1'b0;
    @(negedge clk);
    check32("t1_idle_no_req", imb.im_valid, 1'b0);
    tick();
    check32("t1_first_req_valid", imb.im_valid, 1'b1);
    check32("t1_first_req_addr", imb.im_addr, 32'hBFC0_0000);
    tick();
    check32("t1_wait_no_req", imb.im_valid, 1'b0);
    tick();
    check32("t1_ir0", do_IR, 32'hBFC0_0000);
    check32("t1_npc0", do_NPC, 32'hBFC0_0004);
    check32("t1_valid0", do_valid, 1'b1);
    check32("t1_second_addr", imb.im_addr, 32'hBFC0_0004);
    tick();
    tick();
    check32("t1_ir1", do_IR, 32'hBFC0_0004);
    check32("t1_third_addr", imb.im_addr, 32'hBFC0_0008);

    // 2: stall five cycles while the BFC00008 word returns
    tick();
    di_stall = 1'b1;
    cnt = 0;
    repeat (5) begin
      tick();
      if (imb.im_valid) cnt++;
    end
    di_stall = 1'b0;
    check32("t2_no_req_in_hold", cnt, 32'd0);
    tick();
    check32("t2_release_valid", do_valid, 1'b1);
    check32("t2_release_ir", do_IR, 32'hBFC0_0008);
    check32("t2_release_npc", do_NPC, 32'hBFC0_000C);
    check32("t2_next_addr", imb.im_addr, 32'hBFC0_000C);

    // 3: redirect while a slow response is outstanding
    mem_lat = 3;
    tick();
    redirect_to(32'h0040_0000);
    mem_lat = 1;
    check32("t3_flush_valid", do_valid, 1'b0);
    wait_ivalid("t3_req_after_discard");
    check32("t3_target_addr", imb.im_addr, 32'h0040_0000);
    tick();
    tick();
    check32("t3_target_ir", do_IR, 32'h0040_0000);

    // 4: memory not ready for 3 cycles, redirect on the 2nd
    imb.im_ready = 1'b0;
    check32("t4_req_pending", imb.im_valid, 1'b1);
    tick();
    di_redirect = 1'b1;
    di_target = 32'h0080_0000;
    tick();
    di_redirect = 1'b0;
    check32("t4_switched_valid", imb.im_valid, 1'b1);
    check32("t4_switched_addr", imb.im_addr, 32'h0080_0000);
    tick();
    imb.im_ready = 1'b1;
    check32("t4_accept_addr", imb.im_addr, 32'h0080_0000);
    tick();
    tick();
    check32("t4_ir", do_IR, 32'h0080_0000);
    check32("t4_npc", do_NPC, 32'h0080_0004);

    // 5: misaligned redirect target
    redirect_to(32'h0040_0002);
`ifdef QM_FETCH_ALIGN_CHECK_EN
    cnt = 0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (imb.im_valid) cnt++;
      if (do_valid && do_AdEL) seen = 1'b1;
    end
    check32("t5_no_req_misaligned", cnt, 32'd0);
    check32("t5_adel_seen", seen, 1'b1);
`else
    wait_ivalid("t5_req_misaligned");
    check32("t5_masked_addr", imb.im_addr, 32'h0040_0000);
    check32("t5_adel_tied", do_AdEL, 1'b0);
`endif
    redirect_to(32'h0040_0000);
    wait_ivalid("t5_resume_req");
    check32("t5_resume_addr", imb.im_addr, 32'h0040_0000);

    // PC wrap at the top of the address space
    redirect_to(32'hFFFF_FFFC);
    wait_ivalid("wrap_req");
    check32("wrap_req_addr", imb.im_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    check32("wrap_ir", do_IR, 32'hFFFF_FFFC);
    check32("wrap_npc", do_NPC, 32'h0000_0000);
    check32("wrap_next_addr", imb.im_addr, 32'h0000_0000);

    // 6: reset during WAIT with a stale response the following cycle
    mem_lat = 2;
    tick();
    wait_ivalid("t6_req");
    tick();
    rst = 1'b1;
    mem_xor = 32'h5A5A_A5A5;
    tick();
    rst = 1'b0;
    mem_lat = 1;
    check32("t6_idle_no_req", imb.im_valid, 1'b0);
    tick();
    check32("t6_restart_valid", imb.im_valid, 1'b1);
    check32("t6_restart_addr", imb.im_addr, 32'hBFC0_0000);
    tick();
    tick();
    check32("t6_ir", do_IR, 32'hBFC0_0000 ^ 32'h5A5A_A5A5);
    check32("t6_npc", do_NPC, 32'hBFC0_0004);

    // Mixed stall / ready / redirect traffic, checked by the model
    repeat (300) begin
      di_stall     = ($urandom_range(0, 3) == 0);
      imb.im_ready = ($urandom_range(0, 3) != 0);
      di_redirect  = ($urandom_range(0, 15) == 0);
      t = $urandom;
      t[1:0] = 2'b00;
      di_target = t;
      tick();
    end
    di_stall = 1'b0;
    di_redirect = 1'b0;
    imb.im_ready = 1'b1;
    repeat (8) tick();
    check32("deliveries_nonzero", (deliveries > 20), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
